// File: rtl/timer_device.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers and an interrupt line to CP0.
// Define TIMER_AUTORELOAD_EN to build the MODE=1 auto-reload behaviour; otherwise every mode is one-shot.
module timer_device #(
   parameter logic [31:0] PRESET_RST = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state, state_next;
   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        sticky;

   logic ctrl_wr, ctrl_upd, preset_sel, en_eff, reload;
   logic count_load, count_dec, count_zero, int_enter, en_clear;

   assign ctrl_wr    = we && (addr == 2'd0) && (byteen != 4'd0);
   assign ctrl_upd   = we && (addr == 2'd0) && byteen[0];
   assign preset_sel = we && (addr == 2'd1);
   // The FSM reacts to an EN value written on this very edge.
   assign en_eff     = ctrl_upd ? wdata[0] : en;

`ifdef TIMER_AUTORELOAD_EN
   assign reload = (mode == 2'd1);
`else
   assign reload = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next = state;
      count_load = 1'b0;
      count_dec  = 1'b0;
      count_zero = 1'b0;
      int_enter  = 1'b0;
      en_clear   = 1'b0;
      case (state)
         IDLE: if (en_eff) state_next = LOAD;
         LOAD: begin
            if (!en_eff) state_next = IDLE;
            else begin
               count_load = 1'b1;
               state_next = CNT;
            end
         end
         CNT: begin
            if (!en_eff) state_next = IDLE;
            else if (count > 32'd1) count_dec = 1'b1;
            else begin
               count_zero = 1'b1;
               int_enter  = 1'b1;
               state_next = INT;
            end
         end
         INT: begin
            if (!en_eff)     state_next = IDLE;
            else if (reload) state_next = LOAD;
            else begin
               en_clear   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: register state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en   <= 1'b0;
         mode <= 2'd0;
         im   <= 1'b0;
      end else if (ctrl_upd) begin
         en   <= wdata[0];
         mode <= wdata[2:1];
         im   <= wdata[3];
      end else if (en_clear) begin
         en <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         preset <= PRESET_RST;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (preset_sel && byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        count <= 32'd0;
      else if (count_load) count <= preset;
      else if (count_dec)  count <= count - 32'd1;
      else if (count_zero) count <= 32'd0;
   end

   // Latched on entry to INT so a one-shot interrupt is visible during the INT cycle itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  sticky <= 1'b0;
      else if (ctrl_wr)              sticky <= 1'b0;
      else if (int_enter && !reload) sticky <= 1'b1;
   end

   assign irq = im && (sticky || ((state == INT) && reload));

   always_comb begin
      rdata = 32'd0;
      case (addr)
         2'd0:    rdata = {28'd0, im, mode, en};
         2'd1:    rdata = preset;
         2'd2:    rdata = count;
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: directed scenarios with literal expectations plus randomized bus traffic
// compared every cycle against a behavioural model; honours TIMER_AUTORELOAD_EN like the design.
module tb_timer_device;

   localparam logic [31:0] PRESET_RST = 32'h0000_0007;
`ifdef TIMER_AUTORELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif
   localparam logic [1:0] P_IDLE = 2'd0, P_LOAD = 2'd1, P_CNT = 2'd2, P_INT = 2'd3;

   logic        clk, reset_n, we;
   logic [1:0]  addr;
   logic [3:0]  byteen;
   logic [31:0] wdata, rdata;
   logic        irq;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   timer_device #(.PRESET_RST(PRESET_RST)) dut (
      .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .byteen(byteen),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [1:0]  mode;
      logic        im;
      logic [31:0] preset;
      logic [31:0] count;
      logic        sticky;
      logic [1:0]  phase;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r = '0;
      r.preset = PRESET_RST;
      return r;
   endfunction

   // One clock of the timer's rules applied to the previous model state and the bus inputs.
   function automatic mdl_t mdl_step(mdl_t c, logic w, logic [1:0] a, logic [3:0] be, logic [31:0] d);
      mdl_t n;
      bit wr_ctrl, upd, go, rel;
      n       = c;
      wr_ctrl = w && a == 2'd0 && be != 4'd0;
      upd     = w && a == 2'd0 && be[0];
      rel     = AUTO_RELOAD && c.mode == 2'd1;
      go      = upd ? d[0] : c.en;
      if (upd) begin
         n.en = d[0]; n.mode = d[2:1]; n.im = d[3];
      end
      if (!go) n.phase = P_IDLE;
      else begin
         case (c.phase)
            P_IDLE: n.phase = P_LOAD;
            P_LOAD: begin n.count = c.preset; n.phase = P_CNT; end
            P_CNT: begin
               if (c.count > 1) n.count = c.count - 1;
               else begin
                  n.count = 0; n.phase = P_INT;
                  if (!rel) n.sticky = 1'b1;
               end
            end
            default: begin
               if (rel) n.phase = P_LOAD;
               else begin
                  n.phase = P_IDLE;
                  if (!upd) n.en = 1'b0;
               end
            end
         endcase
      end
      if (wr_ctrl) n.sticky = 1'b0;
      if (w && a == 2'd1)
         for (int i = 0; i < 4; i++) if (be[i]) n.preset[8*i +: 8] = d[8*i +: 8];
      return n;
   endfunction

   function automatic logic [31:0] mdl_read(mdl_t c, logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, c.im, c.mode, c.en};
         2'd1:    return c.preset;
         2'd2:    return c.count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic mdl_irq(mdl_t c);
      return c.im && (c.sticky || (c.phase == P_INT && AUTO_RELOAD && c.mode == 2'd1));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= mdl_reset();
      else          m <= mdl_step(m, we, addr, byteen, wdata);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_rdata", rdata, mdl_read(m, addr));
         check("model_irq", {31'd0, irq}, {31'd0, mdl_irq(m)});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a; byteen = be; wdata = d; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr = a; #1;
      check(name, rdata, exp);
   endtask

   initial begin
      reset_n = 1'b0; we = 1'b0; addr = 2'd0; byteen = 4'd0; wdata = 32'd0;
      idle(3);
      reset_n = 1'b1;
      chk_on  = 1'b1;

      rd_check("rst_ctrl", 2'd0, 32'h0);
      rd_check("rst_preset", 2'd1, 32'h7);
      rd_check("rst_count", 2'd2, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      idle(1);

      // One-shot: PRESET=5, CTRL=EN|IM.
      wr(2'd1, 4'hF, 32'd5);
      wr(2'd0, 4'hF, 32'h9);
      addr = 2'd2;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check("os_count", rdata, 32'(6 - k));
         check("os_irq", {31'd0, irq}, {31'd0, k == 6});
      end
      idle(1);
      rd_check("os_ctrl_en_cleared", 2'd0, 32'h8);
      check("os_irq_held", {31'd0, irq}, 32'd1);
      idle(1);
      wr(2'd0, 4'hF, 32'h0);
      check("os_irq_cleared", {31'd0, irq}, 32'd0);

      // Byte-enable merge and read-only COUNT.
      wr(2'd1, 4'hF, 32'h1122_3344);
      wr(2'd1, 4'b0101, 32'hAABB_CCDD);
      rd_check("be_preset", 2'd1, 32'h11BB_33DD);
      idle(1);
      wr(2'd2, 4'hF, 32'd123);
      rd_check("count_ro", 2'd2, 32'd0);
      idle(1);

`ifdef TIMER_AUTORELOAD_EN
      wr(2'd1, 4'hF, 32'd3);
      wr(2'd0, 4'hF, 32'hB);
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         check("ar_irq_pulse", {31'd0, irq}, {31'd0, (k % 5) == 4});
      end
      wr(2'd0, 4'hF, 32'h3);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         check("ar_masked_irq", {31'd0, irq}, 32'd0);
      end
      wr(2'd0, 4'hF, 32'h0);
      idle(2);
`endif

      // Abort at COUNT=60.
      wr(2'd1, 4'hF, 32'd100);
      wr(2'd0, 4'hF, 32'h9);
      idle(41);
      rd_check("abort_pre", 2'd2, 32'd60);
      wr(2'd0, 4'hF, 32'h0);
      addr = 2'd2;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("abort_hold", rdata, 32'd60);
         check("abort_irq", {31'd0, irq}, 32'd0);
      end

      // Asynchronous reset between edges at COUNT=40.
      wr(2'd0, 4'hF, 32'h9);
      idle(61);
      rd_check("areset_pre", 2'd2, 32'd40);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_count", rdata, 32'd0);
      check("areset_irq", {31'd0, irq}, 32'd0);
      idle(3);
      reset_n = 1'b1;

      // Randomized traffic; presets kept small so timers complete often.
      wr(2'd1, 4'hF, 32'd4);
      for (int c = 0; c < 3000; c++) begin
         addr   = 2'($urandom_range(0, 3));
         we     = ($urandom_range(0, 7) == 0);
         byteen = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         wdata  = (addr == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom;
         if (addr == 2'd0 && we && $urandom_range(0, 1) == 0) wdata[0] = 1'b1;
         @(posedge clk); #1;
      end
      we = 1'b0;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
